// File: rtl/reflector_stage.sv
// Enigma reflector stage: latches a reflector wiring table, validates it one
// entry per cycle, then reflects single ASCII characters through the table.
module reflector_stage #(
  parameter int NLET = 26
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set,
  input  logic [8*NLET-1:0] map_in,
  input  logic              in_valid,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              done,
  output logic              busy,
  output logic              map_err,
  output logic [7:0]        drop_cnt
);
  localparam int            KW     = $clog2(NLET);
  localparam logic [KW-1:0] K_LAST = KW'(NLET - 1);
  localparam logic [7:0]    CH_A   = 8'h41;
  localparam logic [7:0]    CH_Q   = 8'h3F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    LOOKUP = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_busy_next;
  logic [KW-1:0] r_k;
  logic [7:0]    r_table [NLET];
  logic [7:0]    r_din;
  logic [7:0]    r_result;
  logic [7:0]    r_dout;
  logic [7:0]    r_drop;
  logic          r_done;
  logic          r_busy;
  logic          r_err;
  logic [7:0]    w_ent;
  logic [7:0]    w_back;
  logic [7:0]    w_self;
  logic          w_fail;
  logic [7:0]    w_lut;
  logic [7:0]    w_result;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= CH_A) && (c <= (CH_A + 8'(NLET - 1)));
  endfunction

  function automatic logic [KW-1:0] letter_idx(input logic [7:0] c);
    logic [7:0] off;
    off = c - CH_A;
    return off[KW-1:0];
  endfunction

  // Table check for entry r_k: must be a letter, not a fixed point, and an involution.
  always_comb begin
    w_ent  = r_table[r_k];
    w_self = CH_A + 8'(r_k);
    w_back = 8'h00;
    if (is_letter(w_ent)) begin
      w_back = r_table[letter_idx(w_ent)];
    end else begin
      w_back = 8'h00;
    end
    w_fail = !is_letter(w_ent) || (w_ent == w_self) || (w_back != w_self);
  end

  // Reflection result; a letter that maps to a non-letter (e.g. unloaded table) yields '?'.
  always_comb begin
    w_lut    = 8'h00;
    w_result = r_din;
    if (is_letter(r_din)) begin
      w_lut = r_table[letter_idx(r_din)];
    end else begin
      w_lut = 8'h00;
    end
    if (!is_letter(r_din)) begin
      w_result = r_din;
    end else if (r_err || !is_letter(w_lut)) begin
      w_result = CH_Q;
    end else begin
      w_result = w_lut;
    end
  end

  // Next-state logic; set from any state restarts the table check.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (set) begin
          w_next = CHECK;
        end else if (in_valid) begin
          w_next = LOOKUP;
        end else begin
          w_next = IDLE;
        end
      end
      CHECK: begin
        if (set) begin
          w_next = CHECK;
        end else if (r_k == K_LAST) begin
          w_next = IDLE;
        end else begin
          w_next = CHECK;
        end
      end
      LOOKUP:  w_next = set ? CHECK : DONE;
      DONE:    w_next = set ? CHECK : IDLE;
      default: w_next = IDLE;
    endcase
    w_busy_next = (w_next != IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: table, check index, latched character/result and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NLET; i++) begin
        r_table[i] <= 8'h00;
      end
      r_k      <= '0;
      r_err    <= 1'b0;
      r_din    <= 8'h00;
      r_result <= 8'h00;
      r_done   <= 1'b0;
      r_dout   <= 8'h00;
      r_busy   <= 1'b0;
      r_drop   <= 8'h00;
    end else begin
      r_busy <= w_busy_next;
      r_done <= (r_state == DONE) && !set;
      r_dout <= ((r_state == DONE) && !set) ? r_result : 8'h00;
      if (set) begin
        for (int i = 0; i < NLET; i++) begin
          r_table[i] <= map_in[8*NLET-1-8*i -: 8];
        end
        r_k   <= '0;
        r_err <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (in_valid) begin
              r_din <= din;
            end
          end
          CHECK: begin
            r_err <= r_err | w_fail;
            r_k   <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
          end
          LOOKUP:  r_result <= w_result;
          DONE:    r_k <= '0;
          default: r_k <= '0;
        endcase
      end
      // A character arriving while busy, or alongside set, is dropped.
      if (in_valid && ((r_state != IDLE) || set) && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign dout     = r_dout;
  assign done     = r_done;
  assign busy     = r_busy;
  assign map_err  = r_err;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_reflector_stage.sv
// Directed bench for reflector_stage: table load/check, reflection, drops,
// aborts and asynchronous reset, all against hand-computed values.
module tb_reflector_stage;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         set;
  logic [207:0] map_in;
  logic         in_valid;
  logic [7:0]   din;
  logic [7:0]   dout;
  logic         done;
  logic         busy;
  logic         map_err;
  logic [7:0]   drop_cnt;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  logic [7:0] last_dout = 8'h00;

  localparam logic [207:0] MAP_B    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  localparam logic [207:0] MAP_FIX  = "ARUHQSLDPXNGOKMIEBFZCWVJAT";
  localparam logic [207:0] MAP_NINV = "RRUHQSLDPXNGOKMIEBFZCWVJAT";

  reflector_stage #(.NLET(26)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .set      (set),
    .map_in   (map_in),
    .in_valid (in_valid),
    .din      (din),
    .dout     (dout),
    .done     (done),
    .busy     (busy),
    .map_err  (map_err),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      done_seen = done_seen + 1;
      last_dout = dout;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse set with table m, then count cycles with busy high (bounded).
  task automatic load_map(input logic [207:0] m, output int cnt);
    set = 1'b1;
    map_in = m;
    @(negedge clk);
    set = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Send one character, wait (bounded) for done; returns dout and latency in cycles.
  task automatic send_char(input string tag, input logic [7:0] c, output logic [7:0] got, output int lat);
    in_valid = 1'b1;
    din = c;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    got = dout;
  endtask

  initial begin
    int cnt;
    int lat;
    int d0;
    logic [7:0] got;

    reset_n = 1'b0; set = 1'b0; in_valid = 1'b0; din = 8'h00; map_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'h00);
    check_eq("rst_err",  32'(map_err), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Unloaded all-zero table: letters give '?', non-letters pass through.
    send_char("zero_C", "C", got, lat);
    check_eq("zero_C_dout", 32'(got), 32'h3F);
    check_eq("zero_err", 32'(map_err), 32'd0);
    send_char("zero_sp", 8'h20, got, lat);
    check_eq("zero_sp_dout", 32'(got), 32'h20);

    // Standard reflector B.
    load_map(MAP_B, cnt);
    check_eq("B_busy_cycles", 32'(cnt), 32'd26);
    check_eq("B_err", 32'(map_err), 32'd0);
    send_char("B_A", "A", got, lat);
    check_eq("B_A_dout", 32'(got), 32'(8'h59));
    check_eq("B_A_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check_eq("B_after_done", 32'(done), 32'd0);
    check_eq("B_after_dout", 32'(dout), 32'h00);
    send_char("B_Y", "Y", got, lat);
    check_eq("B_Y_dout", 32'(got), 32'(8'h41));
    send_char("B_Q", "Q", got, lat);
    check_eq("B_Q_dout", 32'(got), 32'(8'h45));
    send_char("B_sp", 8'h20, got, lat);
    check_eq("B_sp_dout", 32'(got), 32'h20);

    // Two back-to-back in_valid pulses: second is dropped.
    @(negedge clk);
    d0 = done_seen;
    in_valid = 1'b1; din = "A";
    @(negedge clk);
    din = "B";
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("b2b_dones", 32'(done_seen - d0), 32'd1);
    check_eq("b2b_dout", 32'(last_dout), 32'(8'h59));
    check_eq("b2b_drop", 32'(drop_cnt), 32'd1);

    // map_in changes without set are ignored.
    map_in = MAP_FIX;
    send_char("noset_A", "A", got, lat);
    check_eq("noset_A_dout", 32'(got), 32'(8'h59));

    // Fixed-point table.
    load_map(MAP_FIX, cnt);
    check_eq("fix_busy_cycles", 32'(cnt), 32'd26);
    check_eq("fix_err", 32'(map_err), 32'd1);
    send_char("fix_C", "C", got, lat);
    check_eq("fix_C_dout", 32'(got), 32'h3F);

    // Valid reload clears the error; then a non-involution table sets it again.
    load_map(MAP_B, cnt);
    check_eq("reload_err", 32'(map_err), 32'd0);
    load_map(MAP_NINV, cnt);
    check_eq("ninv_busy_cycles", 32'(cnt), 32'd26);
    check_eq("ninv_err", 32'(map_err), 32'd1);
    send_char("ninv_C", "C", got, lat);
    check_eq("ninv_C_dout", 32'(got), 32'h3F);
    load_map(MAP_B, cnt);

    // set on the LOOKUP cycle aborts the character and restarts the check.
    d0 = done_seen;
    in_valid = 1'b1; din = "A";
    @(negedge clk);
    in_valid = 1'b0;
    set = 1'b1; map_in = MAP_B;
    @(negedge clk);
    set = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("abort_busy_cycles", 32'(cnt), 32'd26);
    check_eq("abort_dones", 32'(done_seen - d0), 32'd0);

    // Asynchronous reset at CHECK k=10.
    set = 1'b1; map_in = MAP_FIX;
    @(negedge clk);
    set = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre_rst_err", 32'(map_err), 32'd1);
    check_eq("pre_rst_drop", 32'(drop_cnt), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_err",  32'(map_err), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_dout", 32'(dout), 32'h00);
    check_eq("mid_rst_drop", 32'(drop_cnt), 32'd0);
    d0 = done_seen;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post_rst_dones", 32'(done_seen - d0), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    load_map(MAP_B, cnt);
    check_eq("post_rst_busy_cycles", 32'(cnt), 32'd26);
    check_eq("post_rst_err", 32'(map_err), 32'd0);

    // Drop counter saturation: set held with in_valid drops every cycle.
    set = 1'b1; in_valid = 1'b1; map_in = MAP_B; din = "A";
    repeat (200) @(negedge clk);
    check_eq("drop_200", 32'(drop_cnt), 32'd200);
    repeat (100) @(negedge clk);
    check_eq("drop_sat", 32'(drop_cnt), 32'd255);
    set = 1'b0; in_valid = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("sat_busy_cycles", 32'(cnt), 32'd26);
    send_char("sat_A", "A", got, lat);
    check_eq("sat_A_dout", 32'(got), 32'(8'h59));
    check_eq("sat_drop_hold", 32'(drop_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reflector_stage.md
REFLECTOR_STAGE -- requirements
Module: reflector_stage

Interface
REQ-001 Parameter NLET, default 26: alphabet size; letters are ASCII 'A' (8'h41) through 'Z' (8'h5A).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 set  input  1  one-cycle pulse: load map_in and start table check.
REQ-005 map_in  input  208  wiring table; entry for letter k (0='A') at bits [207-8k -: 8], ASCII code.
REQ-006 in_valid  input  1  one-cycle pulse from the upstream rotor's done: din is valid.
REQ-007 din  input  8  ASCII character from the upstream rotor.
REQ-008 dout  output  8  reflected character, valid while done=1.
REQ-009 done  output  1  one-cycle pulse: dout valid; drives the downstream rotor's valid.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 map_err  output  1  latched: stored table failed the check.
REQ-012 drop_cnt  output  8  saturating count of in_valid pulses ignored while busy.

Function
REQ-013 FSM states: IDLE, CHECK, LOOKUP, DONE; all outputs registered.
REQ-014 IDLE: set=1 -> latch map_in, clear map_err, k=0, go CHECK; else in_valid=1 -> latch din, go LOOKUP.
REQ-015 set and in_valid high together in IDLE: set wins; the character is dropped and drop_cnt increments.
REQ-016 CHECK: one entry per cycle, k = 0..NLET-1; exits to IDLE after k=NLET-1, i.e. busy for exactly 26 cycles.
REQ-017 Entry k fails if it is outside 'A'..'Z', equals 'A'+k (fixed point), or entry[entry[k]-65] != 'A'+k (not an involution).
REQ-018 Any failing entry sets map_err=1; it holds until the next set, and the check still runs to k=25.
REQ-019 LOOKUP: din in 'A'..'Z' and map_err=0 -> result = entry[din-65]; din not a letter -> result = din (pass-through); map_err=1 -> result = 8'h3F ('?'). Then go DONE.
REQ-020 DONE: done=1 and dout=result for exactly one cycle, then go IDLE.
REQ-021 Latency: in_valid sampled at edge N -> done=1 during the cycle after edge N+2; maximum throughput is one character per 3 cycles.
REQ-022 dout = 8'h00 whenever done=0.
REQ-023 in_valid while busy=1 is ignored; drop_cnt increments by 1, saturates at 255, and clears only on reset.
REQ-024 set while busy (CHECK, LOOKUP or DONE): abort the current operation, load the new map, restart CHECK at k=0; an aborted character produces no done pulse.
REQ-025 Lookup uses only the latched table; map_in changes without set have no effect.

Reset
REQ-026 reset_n=0 asynchronously forces state=IDLE, k=0, done=0, dout=8'h00, busy=0, map_err=0, drop_cnt=0, and stored table all 8'h00.
REQ-027 Lookup before any set, with the all-zero table, gives map_err=0 and an invalid entry; the block outputs 8'h3F for letter inputs in that condition.
REQ-028 Reset asserted mid-CHECK or mid-LOOKUP discards all progress; no done pulse follows the release of reset.

Verification
REQ-029 Load the standard reflector B table (YRUHQSLDPXNGOKMIEBFZCWVJAT), wait 26 cycles -> busy=0, map_err=0; in_valid with din='A' -> done 3 cycles later, dout='Y'; din='Y' -> dout='A'.
REQ-030 Table with entry 0='A' (fixed point), or with a non-involution pair -> map_err=1 after 26 cycles; din='C' -> dout=8'h3F.
REQ-031 din=8'h20 (space) with a valid table -> done pulse, dout=8'h20.
REQ-032 Two in_valid pulses on consecutive cycles -> one done, drop_cnt=1; 300 pulses while busy -> drop_cnt=255.
REQ-033 set pulsed on the LOOKUP cycle -> no done pulse, CHECK restarts, busy stays high 26 more cycles.
REQ-034 reset_n pulled low at CHECK k=10 -> all outputs are at their reset values at once; the next set runs a full 26-cycle check.
